// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: walks row pairs, shifts each row once per bit plane,
// latches it, then holds output enable for a 2^plane weighted time (4-bit BCM).
module hub75_scan_ctrl #(
   parameter int COL_W   = 6,
   parameter int ROW_W   = 4,
   parameter int BASE_OE = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   output logic [ROW_W+COL_W-1:0] fb_addr,
   output logic [1:0]             plane_sel,
   output logic                   panel_clk,
   output logic                   panel_lat,
   output logic                   panel_oe_n,
   output logic [ROW_W-1:0]       panel_row,
   output logic                   busy,
   output logic                   frame_done
);

   // wide enough to hold BASE_OE<<3 without overflow
   localparam int DW = $clog2(BASE_OE * 8) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

   state_t           state;
   logic [1:0]       phase;
   logic [1:0]       plane;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic [DW-1:0]    dcnt;
   logic [DW-1:0]    dlen;
   logic             last_of_frame;

   // display length of the current plane and end-of-frame qualifier
   always_comb begin
      dlen          = DW'(BASE_OE) << plane;
      last_of_frame = (plane == 2'd3) && (row == '1);
   end

   // sequencer: every output is registered together with the state it belongs to
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         phase      <= 2'd0;
         plane      <= 2'd0;
         col        <= '0;
         row        <= '0;
         dcnt       <= '0;
         fb_addr    <= '0;
         plane_sel  <= 2'd0;
         panel_clk  <= 1'b0;
         panel_lat  <= 1'b0;
         panel_oe_n <= 1'b1;
         panel_row  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         panel_lat  <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               fb_addr    <= '0;
               plane_sel  <= 2'd0;
               panel_clk  <= 1'b0;
               panel_oe_n <= 1'b1;
               busy       <= 1'b0;
               phase      <= 2'd0;
               plane      <= 2'd0;
               col        <= '0;
               row        <= '0;
               if (enable) begin
                  state <= SHIFT;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               panel_oe_n <= 1'b1;
               case (phase)
                  2'd0: begin
                     // RAM read in flight; data reaches the pins next cycle
                     phase     <= 2'd1;
                     panel_clk <= 1'b0;
                  end
                  2'd1: begin
                     // data has been stable for a full cycle before this edge
                     phase     <= 2'd2;
                     panel_clk <= 1'b1;
                  end
                  default: begin
                     panel_clk <= 1'b0;
                     phase     <= 2'd0;
                     if (col == '1) begin
                        state     <= LATCH;
                        panel_lat <= 1'b1;
                        panel_row <= row;
                     end else begin
                        col     <= col + 1'b1;
                        fb_addr <= {row, col + 1'b1};
                     end
                  end
               endcase
            end
            LATCH: begin
               state      <= DISPLAY;
               panel_oe_n <= 1'b0;
               dcnt       <= dlen - 1'b1;
               frame_done <= last_of_frame && (dlen == DW'(1));
            end
            DISPLAY: begin
               if (dcnt != '0) begin
                  dcnt       <= dcnt - 1'b1;
                  frame_done <= last_of_frame && (dcnt == DW'(1));
               end else begin
                  panel_oe_n <= 1'b1;
                  col        <= '0;
                  phase      <= 2'd0;
                  if (plane != 2'd3) begin
                     plane     <= plane + 1'b1;
                     plane_sel <= plane + 1'b1;
                     fb_addr   <= {row, {COL_W{1'b0}}};
                     state     <= SHIFT;
                  end else begin
                     plane     <= 2'd0;
                     plane_sel <= 2'd0;
                     row       <= row + 1'b1;
                     fb_addr   <= {row + 1'b1, {COL_W{1'b0}}};
                     state     <= SHIFT;
                     // enable only matters at the frame boundary
                     if (row == '1 && !enable) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        fb_addr <= '0;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl with a 4-column, 2-row-pair, BASE_OE=2 panel.
module tb_hub75_scan_ctrl;

   localparam int COL_W   = 2;
   localparam int ROW_W   = 1;
   localparam int BASE_OE = 2;

   logic                   clk;
   logic                   rst_n;
   logic                   enable;
   logic [ROW_W+COL_W-1:0] fb_addr;
   logic [1:0]             plane_sel;
   logic                   panel_clk;
   logic                   panel_lat;
   logic                   panel_oe_n;
   logic [ROW_W-1:0]       panel_row;
   logic                   busy;
   logic                   frame_done;

   int checks = 0;
   int passed = 0;
   int errs   = 0;
   int exp_row = 0;

   hub75_scan_ctrl #(.COL_W(COL_W), .ROW_W(ROW_W), .BASE_OE(BASE_OE)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .fb_addr(fb_addr),
      .plane_sel(plane_sel), .panel_clk(panel_clk), .panel_lat(panel_lat),
      .panel_oe_n(panel_oe_n), .panel_row(panel_row), .busy(busy),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // one plane of row r: 4 columns x 3 phases, latch, 2<<p display cycles
   task automatic walk_plane(input int p, input int r);
      for (int c = 0; c < 4; c++) begin
         chk("p0_addr",  32'(fb_addr), r * 4 + c);
         chk("p0_clk",   32'(panel_clk), 0);
         chk("p0_oe",    32'(panel_oe_n), 1);
         chk("p0_plane", 32'(plane_sel), p);
         chk("p0_row",   32'(panel_row), exp_row);
         chk("p0_fd",    32'(frame_done), 0);
         tick();
         chk("p1_clk",   32'(panel_clk), 0);
         chk("p1_addr",  32'(fb_addr), r * 4 + c);
         tick();
         chk("p2_clk",   32'(panel_clk), 1);
         chk("p2_addr",  32'(fb_addr), r * 4 + c);
         chk("p2_oe",    32'(panel_oe_n), 1);
         tick();
      end
      exp_row = r;
      chk("lat",      32'(panel_lat), 1);
      chk("lat_oe",   32'(panel_oe_n), 1);
      chk("lat_clk",  32'(panel_clk), 0);
      chk("lat_row",  32'(panel_row), r);
      tick();
      for (int d = 0; d < (BASE_OE << p); d++) begin
         chk("disp_oe",    32'(panel_oe_n), 0);
         chk("disp_lat",   32'(panel_lat), 0);
         chk("disp_plane", 32'(plane_sel), p);
         chk("disp_fd",    32'(frame_done),
             (r == 1 && p == 3 && d == (BASE_OE << p) - 1) ? 1 : 0);
         tick();
      end
      chk("disp_end_oe", 32'(panel_oe_n), 1);
   endtask

   initial begin
      int n;
      int lows;
      rst_n  = 1'b0;
      enable = 1'b0;

      // reset state
      repeat (3) tick();
      chk("rst_oe",    32'(panel_oe_n), 1);
      chk("rst_lat",   32'(panel_lat), 0);
      chk("rst_clk",   32'(panel_clk), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_addr",  32'(fb_addr), 0);
      chk("rst_fd",    32'(frame_done), 0);
      chk("rst_plane", 32'(plane_sel), 0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 0);

      // start: one IDLE->SHIFT cycle, then a full frame walked in detail
      enable = 1'b1;
      tick();
      chk("start_busy", 32'(busy), 1);
      for (int r = 0; r < 2; r++)
         for (int p = 0; p < 4; p++)
            walk_plane(p, r);
      chk("f2_addr", 32'(fb_addr), 0);
      chk("f2_busy", 32'(busy), 1);

      // frame length: pulse at cycle 163 of each frame, 1 cycle wide
      for (int f = 0; f < 2; f++) begin
         n = 0;
         while (frame_done !== 1'b1 && n < 400) begin
            tick();
            n++;
         end
         chk("fd_pos",      n, 163);
         chk("fd_oe_coinc", 32'(panel_oe_n), 0);
         tick();
         chk("fd_width",    32'(frame_done), 0);
         chk("fd_next_oe",  32'(panel_oe_n), 1);
         chk("fd_next_addr", 32'(fb_addr), 0);
         chk("fd_next_busy", 32'(busy), 1);
      end

      // enable drop mid-frame: frame completes, then IDLE
      repeat (50) tick();
      enable = 1'b0;
      n = 50;
      while (frame_done !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      chk("drop_fd_pos", n, 163);
      tick();
      chk("drop_busy", 32'(busy), 0);
      chk("drop_oe",   32'(panel_oe_n), 1);
      chk("drop_addr", 32'(fb_addr), 0);
      chk("drop_fd",   32'(frame_done), 0);
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (panel_oe_n !== 1'b1) lows++;
      end
      chk("drop_oe_lows", lows, 0);
      chk("drop_busy_hold", 32'(busy), 0);

      // reset during DISPLAY
      enable = 1'b1;
      tick();
      n = 0;
      while (panel_oe_n !== 1'b0 && n < 50) begin
         tick();
         n++;
      end
      chk("to_disp", n, 13);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_oe",   32'(panel_oe_n), 1);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_addr", 32'(fb_addr), 0);
      tick();
      tick();
      rst_n = 1'b1;
      exp_row = 0;
      tick();
      chk("rs_busy",  32'(busy), 1);
      chk("rs_addr",  32'(fb_addr), 0);
      chk("rs_plane", 32'(plane_sel), 0);
      walk_plane(0, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
